// File: rtl/fb_serial_subtractor.sv
// fb_serial_subtractor: bit-serial subtractor, d = a - b - bin, LSB first.
// A single full-subtractor cell is fed one bit per clock from two operand
// shift registers; the borrow is carried in a flop between bits.
// Handshake: start is accepted while ready=1; done pulses when d/bout update.
// Optional build macro: SUB_SAT_EN clamps d to zero on a final borrow.
module fb_serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sa_n;
    logic [WIDTH-1:0] sb, sb_n;
    logic [WIDTH-1:0] res, res_n;
    logic             brw, brw_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ready_n;
    logic             done_n;
    logic [WIDTH-1:0] d_n;
    logic             bout_n;

    logic             diff_bit_c;
    logic             brw_step_c;
    logic [WIDTH-1:0] res_shift_c;

    // Full-subtractor cell on the current LSBs and the registered borrow
    always_comb begin
        diff_bit_c  = sa[0] ^ sb[0] ^ brw;
        brw_step_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
        res_shift_c = {diff_bit_c, res[WIDTH-1:1]};
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        res_n   = res;
        brw_n   = brw;
        cnt_n   = cnt;
        d_n     = d;
        bout_n  = bout;

        case (state)
            S_IDLE: begin
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    brw_n   = bin;
                    res_n   = '0;
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sa_n  = sa >> 1;
                sb_n  = sb >> 1;
                brw_n = brw_step_c;
                res_n = res_shift_c;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    bout_n  = brw_step_c;
`ifdef SUB_SAT_EN
                    d_n     = brw_step_c ? '0 : res_shift_c;
`else
                    d_n     = res_shift_c;
`endif
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        ready_n = (state_n == S_IDLE);
        done_n  = (state == S_SHIFT) && (state_n == S_DONE);
    end

    // State, datapath and registered outputs; synchronous reset wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            res   <= res_n;
            brw   <= brw_n;
            cnt   <= cnt_n;
            ready <= ready_n;
            done  <= done_n;
            d     <= d_n;
            bout  <= bout_n;
        end
    end

endmodule

// File: tb/tb_fb_serial_subtractor.sv
// tb_fb_serial_subtractor: directed bench for the bit-serial subtractor, WIDTH=4.
module tb_fb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic [W-1:0] d;
    logic         bout;
    logic         done;

    int checks;
    int failures;

    fb_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .d     (d),
        .bout  (bout),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for {bout,d}
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
`ifdef SUB_SAT_EN
        if (r[W]) r = {1'b1, {W{1'b0}}};
`endif
        return r;
    endfunction

    // One full operation from an idle start, with cycle-exact handshake checks
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W-1:0] exp_d, input logic exp_b, input string tag);
        a = xa; b = xb; bin = xc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~xa; b = ~xb; bin = ~xc;
        check({tag, "_busy"}, {7'd0, ready}, 8'd0);
        for (int i = 0; i < int'(W) - 1; i++) begin
            tick();
            check({tag, "_nodone"}, {7'd0, done}, 8'd0);
        end
        tick();
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_d"}, {4'd0, d}, {4'd0, exp_d});
        check({tag, "_bout"}, {7'd0, bout}, {7'd0, exp_b});
        tick();
        check({tag, "_ready"}, {6'd0, ready, done}, 8'b10);
        check({tag, "_dhold"}, {3'd0, bout, d}, {3'd0, exp_b, exp_d});
    endtask

    initial begin
        logic [W:0] r;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_state", {1'b0, ready, done, bout, d}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        rst_n = 1'b1;
        tick();
        check("idle_ready", {7'd0, ready}, 8'd1);

        // Directed hand-computed cases
        do_op(4'd5, 4'd3, 1'b0, 4'b0010, 1'b0, "basic");
`ifdef SUB_SAT_EN
        do_op(4'd2, 4'd3, 1'b1, 4'b0000, 1'b1, "under");
        do_op(4'd0, 4'd0, 1'b1, 4'b0000, 1'b1, "wrap0");
`else
        do_op(4'd2, 4'd3, 1'b1, 4'b1110, 1'b1, "under");
        do_op(4'd0, 4'd0, 1'b1, 4'b1111, 1'b1, "wrap0");
`endif
        do_op(4'd15, 4'd15, 1'b0, 4'b0000, 1'b0, "wrap15");

        // Start held high: second op only after the idle cycle; mid-op operand changes ignored
        a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
        tick();
        a = 4'd1; b = 4'd9; bin = 1'b1;
        for (int i = 0; i < int'(W) - 1; i++) begin
            tick();
            check("hold_nodone", {6'd0, ready, done}, 8'b00);
        end
        tick();
        check("hold_done1", {2'd0, ready, done, d}, {2'd0, 1'b0, 1'b1, 4'd2});
        a = 4'd9; b = 4'd4; bin = 1'b0;
        tick();
        check("hold_idle", {6'd0, ready, done}, 8'b10);
        tick();
        check("hold_accept", {7'd0, ready}, 8'd0);
        check("hold_dkeep", {4'd0, d}, 8'd2);
        a = 4'd0; b = 4'd0; bin = 1'b1;
        for (int i = 0; i < int'(W) - 1; i++) tick();
        check("hold_nodone2", {7'd0, done}, 8'd0);
        tick();
        check("hold_done2", {2'd0, bout, done, d}, {2'd0, 1'b0, 1'b1, 4'd5});
        start = 1'b0;
        tick();
        check("hold_end", {6'd0, ready, done}, 8'b10);

        // Reset at the second SHIFT edge aborts without a done pulse
        a = 4'd2; b = 4'd3; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst", {1'b0, ready, done, bout, d}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 2; i++) begin
            tick();
            check("midrst_nodone", {6'd0, ready, done}, 8'b10);
        end

        // Exhaustive sweep against the reference model
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            r = ref_sub(v[3:0], v[7:4], v[8]);
            do_op(v[3:0], v[7:4], v[8], r[W-1:0], r[W], "sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
